// File: rtl/sprite_overlay_engine.sv
// Multi-sprite overlay: composites up to NUM_SPRITES colour-keyed sprites from a shared
// synchronous ROM over the background pixel stream, with frame-latched positions and collision flag.
module sprite_overlay_engine #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPR_W       = 64,
  parameter int unsigned SPR_H       = 64,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F,
  localparam int unsigned IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int unsigned AW = $clog2(NUM_SPRITES) + $clog2(SPR_W * SPR_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [9:0]    wr_x,
  input  logic [9:0]    wr_y,
  input  logic          wr_vis,
  input  logic          de_i,
  input  logic [9:0]    x_i,
  input  logic [9:0]    y_i,
  input  logic [11:0]   bg_i,
  output logic [AW-1:0] rom_addr,
  input  logic [11:0]   rom_data,
  output logic          de_o,
  output logic [3:0]    r_o,
  output logic [3:0]    g_o,
  output logic [3:0]    b_o,
  output logic          collision_o
);

  localparam int unsigned SXW = $clog2(SPR_W);
  localparam int unsigned SYW = $clog2(SPR_H);

  logic [9:0]             sh_x   [NUM_SPRITES];
  logic [9:0]             sh_y   [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_vis;
  logic [9:0]             act_x  [NUM_SPRITES];
  logic [9:0]             act_y  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_vis;

  logic          any_hit;
  logic          multi_hit;
  logic [IW-1:0] win_idx;
  logic [9:0]    win_x;
  logic [9:0]    win_y;
  logic [SXW-1:0] win_dx;
  logic [SYW-1:0] win_dy;

  logic          s1_hit, s1_de;
  logic [11:0]   s1_bg;
  logic          s2_hit, s2_de;
  logic [11:0]   s2_bg;
  logic [11:0]   rgb_c;
  logic [11:0]   rgb_q;
  logic          coll_sticky;

  // Shadow entries take writes; active entries copy the (old) shadow at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_vis  <= '0;
      act_vis <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_en && (wr_idx == IW'(i))) begin
          sh_x[i]   <= wr_x;
          sh_y[i]   <= wr_y;
          sh_vis[i] <= wr_vis;
        end
        if (frame_start) begin
          act_x[i]   <= sh_x[i];
          act_y[i]   <= sh_y[i];
          act_vis[i] <= sh_vis[i];
        end
      end
    end
  end

  // Stage 0 hit test; 11-bit bounds clip sprites that run past column/row 1023.
  always_comb begin
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    win_idx   = '0;
    win_x     = '0;
    win_y     = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (act_vis[i] && de_i &&
          ({1'b0, x_i} >= {1'b0, act_x[i]}) &&
          ({1'b0, x_i} <  ({1'b0, act_x[i]} + 11'(SPR_W))) &&
          ({1'b0, y_i} >= {1'b0, act_y[i]}) &&
          ({1'b0, y_i} <  ({1'b0, act_y[i]} + 11'(SPR_H)))) begin
        if (any_hit) begin
          multi_hit = 1'b1;
        end
        any_hit = 1'b1;
        win_idx = IW'(i);
        win_x   = act_x[i];
        win_y   = act_y[i];
      end
    end
  end

  assign win_dx = SXW'(x_i - win_x);
  assign win_dy = SYW'(y_i - win_y);

  // Stage 1: ROM address issue; address is held when nothing hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      s1_hit   <= 1'b0;
      s1_de    <= 1'b0;
      s1_bg    <= '0;
    end else begin
      if (any_hit) begin
        rom_addr <= AW'({win_idx, win_dy, win_dx});
      end
      s1_hit <= any_hit;
      s1_de  <= de_i;
      s1_bg  <= bg_i;
    end
  end

  // Stage 2: align control with the ROM's registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_hit <= 1'b0;
      s2_de  <= 1'b0;
      s2_bg  <= '0;
    end else begin
      s2_hit <= s1_hit;
      s2_de  <= s1_de;
      s2_bg  <= s1_bg;
    end
  end

  // Keyed winner pixel falls back to background, never to a lower-priority sprite.
  always_comb begin
    rgb_c = '0;
    if (s2_de) begin
      if (s2_hit && (rom_data != KEY_COLOR)) begin
        rgb_c = rom_data;
      end else begin
        rgb_c = s2_bg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      de_o  <= 1'b0;
    end else begin
      rgb_q <= rgb_c;
      de_o  <= s2_de;
    end
  end

  assign r_o = rgb_q[11:8];
  assign g_o = rgb_q[7:4];
  assign b_o = rgb_q[3:0];

  // Sticky overlap flag, published and cleared at each frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_sticky <= 1'b0;
      collision_o <= 1'b0;
    end else if (frame_start) begin
      collision_o <= coll_sticky | multi_hit;
      coll_sticky <= 1'b0;
    end else begin
      coll_sticky <= coll_sticky | multi_hit;
    end
  end

endmodule

// File: tb/tb_sprite_overlay_engine.sv
// Directed bench for sprite_overlay_engine with a synchronous ROM model (data = addr[11:0]
// unless overridden); inputs driven and outputs sampled on the falling edge.
module tb_sprite_overlay_engine;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          wr_en;
  logic [1:0]    wr_idx;
  logic [9:0]    wr_x;
  logic [9:0]    wr_y;
  logic          wr_vis;
  logic          de_i;
  logic [9:0]    x_i;
  logic [9:0]    y_i;
  logic [11:0]   bg_i;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic          de_o;
  logic [3:0]    r_o, g_o, b_o;
  logic          collision_o;

  logic          ovr_en;
  logic [11:0]   ovr_val;

  int checks = 0;
  int errors = 0;

  sprite_overlay_engine #(
    .NUM_SPRITES(NS), .SPR_W(64), .SPR_H(64), .KEY_COLOR(12'hF0F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis),
    .de_i(de_i), .x_i(x_i), .y_i(y_i), .bg_i(bg_i),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .de_o(de_o), .r_o(r_o), .g_o(g_o), .b_o(b_o), .collision_o(collision_o)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_data <= ovr_en ? ovr_val : rom_addr[11:0];
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                    input logic vis, input logic with_fs);
    wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_vis = vis;
    frame_start = with_fs;
    cyc();
    wr_en = 1'b0; frame_start = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    de_i = 1'b1; x_i = x; y_i = y;
  endtask

  task automatic idle();
    de_i = 1'b0; x_i = '0; y_i = '0;
  endtask

  function automatic logic [11:0] rgb();
    return {r_o, g_o, b_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0;
    wr_x = '0; wr_y = '0; wr_vis = 1'b0; de_i = 1'b0; x_i = '0; y_i = '0;
    bg_i = 12'h123; ovr_en = 1'b0; ovr_val = '0;
    cyc(); cyc();
    chk("rst_de_o", 32'(de_o), 32'd0);
    chk("rst_rgb", 32'(rgb()), 32'h000);
    chk("rst_coll", 32'(collision_o), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Background pass-through and 3-clock latency.
    pix(10'd10, 10'd10);
    cyc(); cyc();
    chk("lat_de_early", 32'(de_o), 32'd0);
    cyc();
    chk("lat_de", 32'(de_o), 32'd1);
    chk("bg_pass", 32'(rgb()), 32'h123);
    idle();

    // Sprite 0 at (100,200).
    wr(2'd0, 10'd100, 10'd200, 1'b1, 1'b0);
    fs();
    pix(10'd100, 10'd200);
    cyc();
    chk("addr_tl", 32'(rom_addr), 32'd0);
    pix(10'd163, 10'd263);
    cyc();
    chk("addr_br", 32'(rom_addr), 32'd4095);
    pix(10'd164, 10'd200);
    cyc(); cyc();
    chk("rgb_br", 32'(rgb()), 32'hFFF);
    chk("de_br", 32'(de_o), 32'd1);
    cyc();
    chk("rgb_outside", 32'(rgb()), 32'h123);

    // Colour key.
    ovr_en = 1'b1; ovr_val = 12'hF0F;
    pix(10'd101, 10'd201);
    cyc(); cyc(); cyc();
    chk("key_bg", 32'(rgb()), 32'h123);
    ovr_val = 12'h0F0;
    cyc(); cyc(); cyc();
    chk("nonkey_green", 32'(rgb()), 32'h0F0);
    ovr_en = 1'b0;
    idle();

    // Overlap and collision reporting.
    wr(2'd0, 10'd50, 10'd50, 1'b1, 1'b0);
    wr(2'd1, 10'd50, 10'd50, 1'b1, 1'b0);
    fs();
    chk("coll_before", 32'(collision_o), 32'd0);
    pix(10'd60, 10'd60);
    cyc();
    chk("ovl_addr", 32'(rom_addr), 32'd650);
    chk("ovl_sid", 32'(rom_addr[13:12]), 32'd0);
    idle();
    cyc();
    fs();
    chk("coll_set", 32'(collision_o), 32'd1);
    cyc(); cyc();
    chk("coll_stable", 32'(collision_o), 32'd1);
    wr(2'd1, 10'd500, 10'd500, 1'b1, 1'b0);
    fs();
    chk("coll_clear", 32'(collision_o), 32'd0);

    // Write coincident with frame start takes effect one frame later.
    wr(2'd0, 10'd300, 10'd50, 1'b1, 1'b1);
    pix(10'd60, 10'd60);
    cyc();
    chk("old_x_addr", 32'(rom_addr), 32'd650);
    pix(10'd300, 10'd60);
    cyc(); cyc(); cyc();
    chk("old_x_newpos_bg", 32'(rgb()), 32'h123);
    fs();
    pix(10'd300, 10'd60);
    cyc();
    chk("new_x_addr", 32'(rom_addr), 32'd640);
    pix(10'd60, 10'd60);
    cyc(); cyc(); cyc();
    chk("new_x_oldpos_bg", 32'(rgb()), 32'h123);
    idle();

    // Right-edge clipping.
    wr(2'd0, 10'd300, 10'd50, 1'b0, 1'b0);
    wr(2'd2, 10'd1000, 10'd100, 1'b1, 1'b0);
    fs();
    pix(10'd1000, 10'd100);
    cyc();
    chk("clip_addr_l", 32'(rom_addr), 32'd8192);
    pix(10'd1023, 10'd100);
    cyc();
    chk("clip_addr_r", 32'(rom_addr), 32'd8215);
    cyc(); cyc();
    chk("clip_rgb_r", 32'(rgb()), 32'h017);
    pix(10'd0, 10'd100);
    cyc(); cyc(); cyc();
    chk("no_wrap", 32'(rgb()), 32'h123);
    pix(10'd1023, 10'd100);
    cyc(); cyc(); cyc();
    chk("pre_rst_rgb", 32'(rgb()), 32'h017);

    // Mid-line reset blanks immediately and clears visibility.
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_de", 32'(de_o), 32'd0);
    chk("midrst_rgb", 32'(rgb()), 32'h000);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    cyc();
    rst_n = 1'b1;
    fs();
    cyc(); cyc(); cyc();
    chk("post_rst_bg", 32'(rgb()), 32'h123);
    chk("post_rst_de", 32'(de_o), 32'd1);
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_overlay_engine.md
Name: sprite_overlay_engine

Overview:
- Pipelined multi-sprite overlay for the VGA output path. Up to NUM_SPRITES movable rectangular sprites are composited over the incoming background pixel stream.
- Pixel data comes from one shared external synchronous sprite ROM. A colour key gives per-pixel transparency.
- Sprite positions are double-buffered so they change only at frame boundaries, which prevents tearing.
- The block flags bounding-box collisions per frame. It sits between the camera-filter pixel stream and the VGA encoder.

Parameters:
- NUM_SPRITES, 4, number of sprites (1..8).
- SPR_W, 64, sprite width in pixels (power of two).
- SPR_H, 64, sprite height in pixels (power of two).
- KEY_COLOR, 12'hF0F, RGB444 value treated as transparent.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of frame (vertical blank)
- wr_en  in  1  sprite register write strobe
- wr_idx  in  $clog2(NUM_SPRITES) (min 1)  sprite to write
- wr_x  in  10  new sprite left edge
- wr_y  in  10  new sprite top edge
- wr_vis  in  1  new sprite visible flag
- de_i  in  1  display enable of input pixel
- x_i  in  10  input pixel column
- y_i  in  10  input pixel row
- bg_i  in  12  background RGB444 {r,g,b}
- rom_addr  out  AW = $clog2(NUM_SPRITES)+$clog2(SPR_W*SPR_H)  ROM address {sprite_id, sy, sx}
- rom_data  in  12  ROM word, valid one clock after rom_addr
- de_o  out  1  delayed display enable
- r_o  out  4  output red
- g_o  out  4  output green
- b_o  out  4  output blue
- collision_o  out  1  at least two visible sprites overlapped during the previous frame

Behaviour:
- Reset (async assert, sync release):
  - All shadow and active x/y set to 0 and vis set to 0.
  - All pipeline registers, rom_addr, de_o, r_o/g_o/b_o, collision_o and the sticky collision flag set to 0.
  - An assertion mid-frame immediately blanks the outputs.
- Register write: on wr_en, the shadow entry wr_idx takes {wr_x, wr_y, wr_vis} at the clock edge. Writes with wr_idx >= NUM_SPRITES are ignored.
- Frame latch: on frame_start, all active entries take the shadow values.
- wr_en and frame_start in the same cycle: active takes the OLD shadow value; the new write applies from the next frame_start.
- Hit test (stage 0, combinational on inputs), evaluated for each sprite i:
  - Condition: active vis_i and de_i, x_i >= sx_i and x_i < sx_i+SPR_W, y_i >= sy_i and y_i < sy_i+SPR_H.
  - Compare with 11-bit sums so a sprite extending past 1023 does not wrap and is clipped instead.
- Priority: the lowest-index hitting sprite wins. Only one ROM fetch is made per pixel.
- If the winning sprite's pixel equals KEY_COLOR, the background is shown. Lower-priority sprites are not revealed; this is a decided limitation.
- Pipeline, with input sampled at edge E:
  - Edge E: rom_addr <= {win_idx, y_i-sy, x_i-sx} using the low bits. The stage-1 register holds hit, de_i and bg_i.
  - Edge E+1: the ROM registers rom_data. The stage-2 register holds hit, de and bg.
  - Edge E+2: the output register drives {r_o,g_o,b_o} and de_o.
  - Total latency is 3 clocks for every signal; de_o tracks de_i delayed by 3.
- Output select:
  - !de → 0.
  - hit and rom_data != KEY_COLOR → rom_data.
  - Otherwise → bg.
- If there is no hit, rom_addr holds its last value; do not care, because the data is unused.
- Collision: a sticky flag sets on any de_i cycle where two or more visible sprites hit the same pixel.
- On frame_start, collision_o <= (sticky flag OR the current cycle's collision), and the sticky flag clears. collision_o is therefore stable for one frame and reports the previous frame.
- Position changes take effect only after frame_start, never mid-frame.

Test Plan:
- Reset, then all vis=0, bg_i=12'h123, de_i=1 → after 3 clocks r/g/b = 1/2/3 and de_o=1, with rom_addr never used.
- Write sprite 0 at (100,200), vis=1, then frame_start; drive pixel (100,200) → rom_addr = 0. Drive (163,263) → rom_addr = 4095. Drive (164,200) → background. Check 3-cycle latency with ROM model data = addr[11:0].
- ROM returns 12'hF0F at a hit pixel → background output. The same pixel with 12'h0F0 → g_o=F, r_o=b_o=0.
- Sprites 0 and 1 both at (50,50), vis=1 → rom_addr sprite_id field = 0. After the next frame_start collision_o=1; after a frame with no overlap collision_o=0.
- Write sprite 0 x=300 in the same cycle as frame_start → the current frame still uses the old x; the following frame uses x=300.
- Sprite at x=1000 (extends past 1023) → columns 1000..1023 hit with no wrap to column 0. Assert rst_n low mid-line → outputs go to 0 immediately and vis is cleared.
